// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types: operation codes, opcodes and the decoded bundle.
// Operation code 0 is reserved for illegal instructions, so cleared storage decodes as illegal.
package decode_queue_pkg;

  localparam int OPT_W = 6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [OPT_W-1:0] {
    OPT_ILLEGAL = 6'd0,
    OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
    OPT_SB, OPT_SH, OPT_SW,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
    OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR,
    OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
  } opt_e;

  typedef struct packed {
    opt_e        opt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side handshakes of the decode queue.
// slave is the queue itself; master is the fetch/dispatch environment.
interface decode_queue_if #(parameter int ADDR_W = 32);
  import decode_queue_pkg::*;

  logic              if_valid_in;
  logic              if_ready_out;
  logic [31:0]       if_inst_in;
  logic [ADDR_W-1:0] if_pc_in;
  logic              if_pred_taken_in;

  logic              ds_valid_out;
  logic              ds_ready_in;
  opt_e              ds_opt_out;
  logic [4:0]        ds_rd_out;
  logic [4:0]        ds_rs1_out;
  logic [4:0]        ds_rs2_out;
  logic [31:0]       ds_imm_out;
  logic [ADDR_W-1:0] ds_pc_out;
  logic              ds_pred_taken_out;
  logic              ds_illegal_out;

  modport slave (
    input  if_valid_in, if_inst_in, if_pc_in, if_pred_taken_in, ds_ready_in,
    output if_ready_out, ds_valid_out, ds_opt_out, ds_rd_out, ds_rs1_out,
           ds_rs2_out, ds_imm_out, ds_pc_out, ds_pred_taken_out, ds_illegal_out
  );

  modport master (
    output if_valid_in, if_inst_in, if_pc_in, if_pred_taken_in, ds_ready_in,
    input  if_ready_out, ds_valid_out, ds_opt_out, ds_rd_out, ds_rs1_out,
           ds_rs2_out, ds_imm_out, ds_pc_out, ds_pred_taken_out, ds_illegal_out
  );
endinterface

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I decoder: raw instruction to {opt, rd, rs1, rs2, imm, illegal}.
// Any illegal encoding collapses to an all-zero bundle with illegal set.
module inst_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst_in,
  output dec_t        dec_out
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  dec_t        d;
  logic        ill;

  assign opcode = inst_in[6:0];
  assign f_rd   = inst_in[11:7];
  assign f3     = inst_in[14:12];
  assign f_rs1  = inst_in[19:15];
  assign f_rs2  = inst_in[24:20];
  assign f7     = inst_in[31:25];

  assign imm_i  = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b  = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_u  = {inst_in[31:12], 12'b0};
  assign imm_j  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
  assign imm_sh = {27'b0, f_rs2};

  always_comb begin
    d     = '0;
    ill   = 1'b0;
    case (opcode)
      OP_LUI:   begin d.opt = OPT_LUI;   d.rd = f_rd; d.imm = imm_u; end
      OP_AUIPC: begin d.opt = OPT_AUIPC; d.rd = f_rd; d.imm = imm_u; end
      OP_JAL:   begin d.opt = OPT_JAL;   d.rd = f_rd; d.imm = imm_j; end
      OP_JALR: begin
        d.opt = OPT_JALR; d.rd = f_rd; d.rs1 = f_rs1; d.imm = imm_i;
        ill = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        d.rs1 = f_rs1; d.rs2 = f_rs2; d.imm = imm_b;
        case (f3)
          3'b000:  d.opt = OPT_BEQ;
          3'b001:  d.opt = OPT_BNE;
          3'b100:  d.opt = OPT_BLT;
          3'b101:  d.opt = OPT_BGE;
          3'b110:  d.opt = OPT_BLTU;
          3'b111:  d.opt = OPT_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d.rd = f_rd; d.rs1 = f_rs1; d.imm = imm_i;
        case (f3)
          3'b000:  d.opt = OPT_LB;
          3'b001:  d.opt = OPT_LH;
          3'b010:  d.opt = OPT_LW;
          3'b100:  d.opt = OPT_LBU;
          3'b101:  d.opt = OPT_LHU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        d.rs1 = f_rs1; d.rs2 = f_rs2; d.imm = imm_s;
        case (f3)
          3'b000:  d.opt = OPT_SB;
          3'b001:  d.opt = OPT_SH;
          3'b010:  d.opt = OPT_SW;
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        d.rd = f_rd; d.rs1 = f_rs1; d.imm = imm_i;
        case (f3)
          3'b000: d.opt = OPT_ADDI;
          3'b010: d.opt = OPT_SLTI;
          3'b011: d.opt = OPT_SLTIU;
          3'b100: d.opt = OPT_XORI;
          3'b110: d.opt = OPT_ORI;
          3'b111: d.opt = OPT_ANDI;
          3'b001: begin
            d.opt = OPT_SLLI; d.imm = imm_sh;
            ill = (f7 != F7_ZERO);
          end
          default: begin
            d.imm = imm_sh;
            if (f7 == F7_ZERO)     d.opt = OPT_SRLI;
            else if (f7 == F7_ALT) d.opt = OPT_SRAI;
            else                   ill = 1'b1;
          end
        endcase
      end
      OP_OP: begin
        d.rd = f_rd; d.rs1 = f_rs1; d.rs2 = f_rs2;
        if (f7 == F7_ZERO) begin
          case (f3)
            3'b000:  d.opt = OPT_ADD;
            3'b001:  d.opt = OPT_SLL;
            3'b010:  d.opt = OPT_SLT;
            3'b011:  d.opt = OPT_SLTU;
            3'b100:  d.opt = OPT_XOR;
            3'b101:  d.opt = OPT_SRL;
            3'b110:  d.opt = OPT_OR;
            default: d.opt = OPT_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d.opt = OPT_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d.opt = OPT_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      // FENCE has no effect on an in-order core: issue it as a NOP.
      OP_FENCE: d.opt = OPT_ADDI;
      default:  ill = 1'b1;
    endcase
    if (ill) begin
      d         = '0;
      d.illegal = 1'b1;
    end
  end

  assign dec_out = d;

endmodule

// File: rtl/decode_queue.sv
// Decode-at-enqueue instruction queue: DEPTH-entry circular buffer between fetch and dispatch.
// 1-cycle latency, no bypass; full blocks fetch, empty or rdy_in low drops dispatch valid.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  decode_queue_if.slave    q_if,
  output logic [CNT_W-1:0] count_out
);

  dec_t              dec_new;
  dec_t              dec_q  [DEPTH];
  dec_t              dec_d  [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic              pred_q [DEPTH];
  logic              pred_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, flush_en;

  inst_decode u_dec (
    .inst_in (q_if.if_inst_in),
    .dec_out (dec_new)
  );

  assign q_if.if_ready_out = rdy_in && (cnt_q < CNT_W'(DEPTH));
  assign q_if.ds_valid_out = rdy_in && (cnt_q != '0);

  assign push     = q_if.if_valid_in && q_if.if_ready_out && !flush_in;
  assign pop      = q_if.ds_valid_out && q_if.ds_ready_in;
  // rdy_in is a global enable, so a flush during a stall is held off too.
  assign flush_en = rdy_in && flush_in;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    pc_d   = pc_q;
    pred_d = pred_q;
    if (flush_en) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        dec_d[tail_q]  = dec_new;
        pc_d[tail_q]   = q_if.if_pc_in;
        pred_d[tail_q] = q_if.if_pred_taken_in;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      dec_q  <= '{default: '0};
      pc_q   <= '{default: '0};
      pred_q <= '{default: 1'b0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
      pc_q   <= pc_d;
      pred_q <= pred_d;
    end
  end

  assign q_if.ds_opt_out        = dec_q[head_q].opt;
  assign q_if.ds_rd_out         = dec_q[head_q].rd;
  assign q_if.ds_rs1_out        = dec_q[head_q].rs1;
  assign q_if.ds_rs2_out        = dec_q[head_q].rs2;
  assign q_if.ds_imm_out        = dec_q[head_q].imm;
  assign q_if.ds_illegal_out    = dec_q[head_q].illegal;
  assign q_if.ds_pc_out         = pc_q[head_q];
  assign q_if.ds_pred_taken_out = pred_q[head_q];
  assign count_out              = cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4): decode vectors, full/wrap, flush, stall, async reset.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rdy, flush;
  logic [2:0] count;
  int         checks = 0;
  int         passes = 0;

  decode_queue_if #(.ADDR_W(32)) bus ();

  decode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rdy_in    (rdy),
    .flush_in  (flush),
    .q_if      (bus),
    .count_out (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    bus.if_valid_in      = 1'b1;
    bus.if_inst_in       = inst;
    bus.if_pc_in         = pc;
    bus.if_pred_taken_in = pred;
    step();
    bus.if_valid_in      = 1'b0;
  endtask

  task automatic pop_one();
    bus.ds_ready_in = 1'b1;
    step();
    bus.ds_ready_in = 1'b0;
  endtask

  task automatic dv(input string tag, input logic [31:0] inst, input opt_e opt,
                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [31:0] imm, input logic ill);
    offer(inst, 32'h200, 1'b0);
    chk({tag, ".valid"}, 32'(bus.ds_valid_out), 32'd1);
    chk({tag, ".opt"},   32'(bus.ds_opt_out), 32'(opt));
    chk({tag, ".rd"},    32'(bus.ds_rd_out), 32'(rd));
    chk({tag, ".rs1"},   32'(bus.ds_rs1_out), 32'(rs1));
    chk({tag, ".rs2"},   32'(bus.ds_rs2_out), 32'(rs2));
    chk({tag, ".imm"},   bus.ds_imm_out, imm);
    chk({tag, ".ill"},   32'(bus.ds_illegal_out), 32'(ill));
    pop_one();
    chk({tag, ".cnt"},   32'(count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0;
    bus.if_valid_in = 1'b0; bus.if_inst_in = '0; bus.if_pc_in = '0;
    bus.if_pred_taken_in = 1'b0; bus.ds_ready_in = 1'b0;
    #12;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.dsv", 32'(bus.ds_valid_out), 32'd0);
    chk("rst.ifr_nordy", 32'(bus.if_ready_out), 32'd0);
    chk("rst.opt", 32'(bus.ds_opt_out), 32'd0);
    chk("rst.imm", bus.ds_imm_out, 32'd0);
    chk("rst.pc", bus.ds_pc_out, 32'd0);
    rdy = 1'b1;
    #1;
    chk("rst.ifr", 32'(bus.if_ready_out), 32'd1);
    rst = 1'b0;
    step();

    // First instruction, then a simultaneous push and pop.
    offer(32'h00500093, 32'h100, 1'b1);
    chk("addi.valid", 32'(bus.ds_valid_out), 32'd1);
    chk("addi.opt", 32'(bus.ds_opt_out), 32'(OPT_ADDI));
    chk("addi.rd", 32'(bus.ds_rd_out), 32'd1);
    chk("addi.rs1", 32'(bus.ds_rs1_out), 32'd0);
    chk("addi.imm", bus.ds_imm_out, 32'd5);
    chk("addi.ill", 32'(bus.ds_illegal_out), 32'd0);
    chk("addi.pc", bus.ds_pc_out, 32'h100);
    chk("addi.pred", 32'(bus.ds_pred_taken_out), 32'd1);
    chk("addi.cnt", 32'(count), 32'd1);
    bus.ds_ready_in = 1'b1;
    offer(32'h00A00113, 32'h104, 1'b0);
    bus.ds_ready_in = 1'b0;
    chk("pp.cnt", 32'(count), 32'd1);
    chk("pp.rd", 32'(bus.ds_rd_out), 32'd2);
    chk("pp.imm", bus.ds_imm_out, 32'd10);
    chk("pp.pc", bus.ds_pc_out, 32'h104);
    pop_one();
    chk("pp.cnt0", 32'(count), 32'd0);
    chk("pp.dsv0", 32'(bus.ds_valid_out), 32'd0);

    dv("srai",   32'h40535293, OPT_SRAI,    5'd5, 5'd6, 5'd0, 32'd5,        1'b0);
    dv("badsh",  32'h02535293, OPT_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1);
    dv("beq",    32'hFE000EE3, OPT_BEQ,     5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
    dv("sw",     32'h0020A423, OPT_SW,      5'd0, 5'd1, 5'd2, 32'd8,        1'b0);
    dv("lui",    32'h123450B7, OPT_LUI,     5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0);
    dv("add",    32'h002081B3, OPT_ADD,     5'd3, 5'd1, 5'd2, 32'd0,        1'b0);
    dv("sub",    32'h402081B3, OPT_SUB,     5'd3, 5'd1, 5'd2, 32'd0,        1'b0);
    dv("fence",  32'h0FF0000F, OPT_ADDI,    5'd0, 5'd0, 5'd0, 32'd0,        1'b0);
    dv("jal",    32'h008000EF, OPT_JAL,     5'd1, 5'd0, 5'd0, 32'd8,        1'b0);
    dv("cmp16",  32'h00000001, OPT_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1);
    dv("ecall",  32'h00000073, OPT_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1);
    dv("badld",  32'h0000B003, OPT_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1);

    // Fill to DEPTH with dispatch stalled, offer a fifth, drain across the wrap.
    for (int i = 1; i <= 4; i++) offer(32'h00000093 | (32'(i) << 20), 32'(i), 1'b0);
    chk("full.cnt", 32'(count), 32'd4);
    chk("full.ifr", 32'(bus.if_ready_out), 32'd0);
    offer(32'h00500093, 32'h5, 1'b0);
    chk("full.cnt5", 32'(count), 32'd4);
    pop_one();
    chk("full.cnt3", 32'(count), 32'd3);
    chk("full.ifr1", 32'(bus.if_ready_out), 32'd1);
    offer(32'h00500093, 32'h5, 1'b0);
    chk("full.cnt4", 32'(count), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      chk("wrap.imm", bus.ds_imm_out, 32'(i));
      chk("wrap.pc", bus.ds_pc_out, 32'(i));
      pop_one();
    end
    chk("wrap.cnt", 32'(count), 32'd0);

    // Flush with a concurrent offer: nothing survives, the offer is dropped.
    for (int i = 1; i <= 3; i++) offer(32'h00100093, 32'h300, 1'b0);
    chk("fl.cnt3", 32'(count), 32'd3);
    flush = 1'b1;
    offer(32'h00700093, 32'h304, 1'b0);
    flush = 1'b0;
    chk("fl.cnt", 32'(count), 32'd0);
    chk("fl.dsv", 32'(bus.ds_valid_out), 32'd0);
    offer(32'h00800093, 32'h308, 1'b0);
    chk("fl.after", 32'(count), 32'd1);
    chk("fl.imm", bus.ds_imm_out, 32'd8);
    pop_one();

    // Global stall with both sides active.
    offer(32'h00100093, 32'h400, 1'b0);
    offer(32'h00200093, 32'h404, 1'b0);
    rdy = 1'b0;
    bus.if_valid_in = 1'b1;
    bus.ds_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st.cnt", 32'(count), 32'd2);
      chk("st.ifr", 32'(bus.if_ready_out), 32'd0);
      chk("st.dsv", 32'(bus.ds_valid_out), 32'd0);
    end
    bus.if_valid_in = 1'b0;
    bus.ds_ready_in = 1'b0;
    rdy = 1'b1;
    #1;
    chk("st.head", bus.ds_pc_out, 32'h400);
    step();
    chk("st.cnt2", 32'(count), 32'd2);

    // Asynchronous reset between edges with 3 entries queued.
    offer(32'h00300093, 32'h408, 1'b0);
    chk("ar.cnt3", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar.cnt", 32'(count), 32'd0);
    chk("ar.dsv", 32'(bus.ds_valid_out), 32'd0);
    chk("ar.imm", bus.ds_imm_out, 32'd0);
    #1 rst = 1'b0;
    step();
    chk("ar.ifr", 32'(bus.if_ready_out), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised RV32I decode stage between instruction fetch and dispatch. It accepts raw instructions with PC and branch prediction over a valid/ready handshake and decodes them at enqueue. Decoded bundles are held in a DEPTH-entry circular queue and presented to dispatch over a second valid/ready handshake. Unlike the plain combinational decoder, it adds buffering, back-pressure, flush, a global stall and illegal-instruction detection.

## Interface
- DEPTH, 4: queue entries; power of two, minimum 2.
- ADDR_W, 32: PC width.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global enable; when low, all state holds.
- flush_in  input  1  discard every queued entry (mispredict or exception).
- if_valid_in  input  1  fetch offers an instruction.
- if_ready_out  output  1  queue can accept.
- if_inst_in  input  32  raw instruction.
- if_pc_in  input  ADDR_W  instruction PC.
- if_pred_taken_in  input  1  fetch branch prediction.
- ds_valid_out  output  1  head entry is valid.
- ds_ready_in  input  1  dispatch takes the head entry.
- ds_opt_out  output  `OPT_W  operation code.
- ds_rd_out, ds_rs1_out, ds_rs2_out  output  5 each  register indices.
- ds_imm_out  output  32  immediate.
- ds_pc_out  output  ADDR_W  head PC.
- ds_pred_taken_out  output  1  head prediction.
- ds_illegal_out  output  1  head instruction is illegal.
- count_out  output  $clog2(DEPTH)+1  occupancy.

## Operation
- **Push:** `if_valid_in && if_ready_out && rdy_in && !flush_in`. The decoded bundle is written at the tail and the tail advances modulo DEPTH.
- **Pop:** `ds_valid_out && ds_ready_in`. The head advances modulo DEPTH.
- **if_ready_out:** `rdy_in && count < DEPTH`. There is no pop-through when full, so `if_ready_out` never depends on `ds_ready_in`.
- **ds_valid_out:** `rdy_in && count != 0`. Head fields are driven directly from queue storage.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Flush:** highest priority. Head, tail and count go to 0; a push or pop in the same cycle is ignored.
- **Decode rules:**
  - Fields not used by the format are 0.
  - rd is 0 for branch and store.
  - rs1 and rs2 are 0 for LUI, AUIPC and JAL.
  - rs2 is 0 for I-type.
- **Immediates:** per RISC-V format, sign-extended to 32 bits. U-type has imm[11:0]=0. B and J types have imm[0]=0.
- **Shifts:** SLLI, SRLI and SRAI select by funct3=001 or 101, with funct7 bit 30 choosing SRAI. imm = zero-extended shamt[4:0].
- **FENCE (0001111):** decoded as `ADDI with rd=rs1=0 and imm=0 (a NOP), illegal=0.
- **Illegal (illegal=1, opt=`ILLEGAL, all register fields and imm = 0). Entries are still queued in order.** An instruction is illegal on any of:
  - unknown opcode, or SYSTEM (1110011);
  - branch funct3 of 010 or 011;
  - load funct3 of 011, 110 or 111;
  - store funct3 greater than 010;
  - OP funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101};
  - shift-immediate with inst[25]=1, or with funct7 not in {0000000, 0100000} (0100000 allowed only for funct3=101);
  - JALR funct3 not equal to 000;
  - inst[1:0] not equal to 11.

## Timing
- **Reset:** all pointers, count and storage are 0. `ds_valid_out`=0, all ds_* fields=0, `count_out`=0. `if_ready_out`=1 once `rdy_in`=1.
- **Latency:** an instruction accepted at edge N is visible on ds_* from edge N onward (1 cycle). There is no same-cycle bypass.
- **Throughput:** 1 push and 1 pop per cycle.
- **rdy_in low:** queue contents, pointers and count hold. Both handshakes are deasserted.
- **Reset mid-operation:** queue empties immediately, asynchronously.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0. count_out is the full/empty discriminator.

## Structure
- Shared header utils.v holds:
  - `OPT_W and the opt encodings, with `ILLEGAL = 0;
  - opcode localparams;
  - the `DATA_RANGE macro.
- Sub-module `inst_decode` is purely combinational: inst → {opt, rd, rs1, rs2, imm, illegal}. It is instantiated once on the enqueue path.
- decode_queue itself contains the storage array, pointers, count and handshake logic.

## Test plan
- **Reset:** assert `rst_in` mid-stream with 3 entries queued → immediately `count_out`=0 and `ds_valid_out`=0; after release, `if_ready_out`=1.
- **Push 0x00500093:**
  - → next cycle `ds_valid_out`=1, opt=`ADDI, rd=1, rs1=0, imm=5, illegal=0.
  - A pop the same cycle → `count_out`=0.
- **Shifts and branch:**
  - Push 0x40535293 → `SRAI, rd=5, rs1=6, imm=5.
  - Push 0x02535293 → illegal=1, opt=`ILLEGAL.
  - Push 0xFE000EE3 → `BEQ, imm=0xFFFFFFFC.
- **Full (DEPTH=4), `ds_ready_in`=0:**
  - Push 4 → `if_ready_out`=0 and count=4; a 5th offer is not accepted.
  - One pop → `if_ready_out`=1 next cycle; order is preserved across wrap.
- **Flush with a concurrent push:** 3 entries queued, `flush_in`=1 together with `if_valid_in`=1 → next cycle count=0 and `ds_valid_out`=0; the offered instruction is not stored.
- **Stall:** `rdy_in`=0 for 5 cycles while both sides are valid → no count change, and both handshakes stay low.
